// File: rtl/cc_reorder_merge_unit_if.sv
// Bus bundle for cc_reorder_merge_unit: MEM R channel, hit flag/data writers, INCT R channel, counters.
interface cc_reorder_merge_unit_if #(
  parameter int DATA_WIDTH = 64,
  parameter int BURST_LEN  = 8
);
  localparam int OFS_W  = $clog2(BURST_LEN);
  localparam int LINE_W = DATA_WIDTH * BURST_LEN;
  localparam int HENT_W = OFS_W + LINE_W;

  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic                  mem_rlast_i;
  logic                  mem_rvalid_i;
  logic                  mem_rready_o;
  logic                  hit_flag_fifo_afull_o;
  logic                  hit_flag_fifo_wren_i;
  logic                  hit_flag_fifo_wdata_i;
  logic                  hit_data_fifo_afull_o;
  logic                  hit_data_fifo_wren_i;
  logic [HENT_W-1:0]     hit_data_fifo_wdata_i;
  logic [DATA_WIDTH-1:0] inct_rdata_o;
  logic                  inct_rlast_o;
  logic                  inct_rvalid_o;
  logic                  inct_rready_i;
  logic [31:0]           hit_cnt_o;
  logic [31:0]           miss_cnt_o;

  modport slave (
    input  mem_rdata_i, mem_rlast_i, mem_rvalid_i,
    output mem_rready_o,
    output hit_flag_fifo_afull_o,
    input  hit_flag_fifo_wren_i, hit_flag_fifo_wdata_i,
    output hit_data_fifo_afull_o,
    input  hit_data_fifo_wren_i, hit_data_fifo_wdata_i,
    output inct_rdata_o, inct_rlast_o, inct_rvalid_o,
    input  inct_rready_i,
    output hit_cnt_o, miss_cnt_o
  );

  modport master (
    output mem_rdata_i, mem_rlast_i, mem_rvalid_i,
    input  mem_rready_o,
    input  hit_flag_fifo_afull_o,
    output hit_flag_fifo_wren_i, hit_flag_fifo_wdata_i,
    input  hit_data_fifo_afull_o,
    output hit_data_fifo_wren_i, hit_data_fifo_wdata_i,
    input  inct_rdata_o, inct_rlast_o, inct_rvalid_o,
    output inct_rready_i,
    input  hit_cnt_o, miss_cnt_o
  );
endinterface

// File: rtl/cc_reorder_merge_unit.sv
// In-order merge of hit lines (critical-word-first) and MEM miss bursts onto the INCT R channel.
// Optional performance counters: define CC_RMU_PERF_CNT_EN.
module cc_rmu_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 4,
  parameter int AFULL = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         afull
);
  localparam int AW  = $clog2(DEPTH);
  localparam int THR = DEPTH - AFULL;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr, wr_nxt, rd_nxt, cnt_nxt;
  logic         full, push_ok, pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
  assign pop_ok  = pop && !empty;
  // a full FIFO still takes a write when the head leaves in the same cycle
  assign push_ok = push && (!full || pop_ok);
  assign wr_nxt  = wr_ptr + (AW+1)'(push_ok);
  assign rd_nxt  = rd_ptr + (AW+1)'(pop_ok);
  assign cnt_nxt = wr_nxt - rd_nxt;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      afull  <= 1'b0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      afull  <= (int'(cnt_nxt) >= THR);
    end
  end
endmodule

// state | meaning
// IDLE  | no burst in flight, waiting for a flag
// MISS  | MEM R burst passed straight through to INCT
// HIT   | head hit line streamed from the hit data FIFO
module cc_reorder_merge_unit #(
  parameter int DATA_WIDTH  = 64,
  parameter int BURST_LEN   = 8,
  parameter int FLAG_DEPTH  = 4,
  parameter int FLAG_AFULL  = 2,
  parameter int HDATA_DEPTH = 2,
  parameter int HDATA_AFULL = 1
) (
  input logic                    clk,
  input logic                    rst_n,
  cc_reorder_merge_unit_if.slave bus
);
  localparam int OFS_W  = $clog2(BURST_LEN);
  localparam int LINE_W = DATA_WIDTH * BURST_LEN;
  localparam int HENT_W = OFS_W + LINE_W;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MISS = 2'd1;
  localparam logic [1:0] HIT  = 2'd2;
  localparam logic [OFS_W-1:0] CNT_LAST = OFS_W'(BURST_LEN - 1);

  logic [1:0]            state, state_nxt;
  logic [OFS_W-1:0]      cnt, cnt_nxt, word_idx;
  logic                  flag_head, flag_empty, flag_pop;
  logic [HENT_W-1:0]     hent;
  logic                  hdata_empty, hdata_pop;
  logic                  burst_end;
  logic [DATA_WIDTH-1:0] words [BURST_LEN];
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid, rlast, mrdy;

  cc_rmu_fifo #(.W(1), .DEPTH(FLAG_DEPTH), .AFULL(FLAG_AFULL)) u_flag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.hit_flag_fifo_wren_i),
    .wdata (bus.hit_flag_fifo_wdata_i),
    .pop   (flag_pop),
    .rdata (flag_head),
    .empty (flag_empty),
    .afull (bus.hit_flag_fifo_afull_o)
  );

  cc_rmu_fifo #(.W(HENT_W), .DEPTH(HDATA_DEPTH), .AFULL(HDATA_AFULL)) u_hdata_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.hit_data_fifo_wren_i),
    .wdata (bus.hit_data_fifo_wdata_i),
    .pop   (hdata_pop),
    .rdata (hent),
    .empty (hdata_empty),
    .afull (bus.hit_data_fifo_afull_o)
  );

  always_comb begin
    for (int k = 0; k < BURST_LEN; k++) words[k] = hent[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // critical-word-first: offset wraps naturally in OFS_W bits
  assign word_idx = hent[HENT_W-1:LINE_W] + cnt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    flag_pop  = 1'b0;
    hdata_pop = 1'b0;
    burst_end = 1'b0;
    rvalid    = 1'b0;
    rdata     = '0;
    rlast     = 1'b0;
    mrdy      = 1'b0;
    case (state)
      MISS: begin
        rvalid    = bus.mem_rvalid_i;
        rdata     = bus.mem_rdata_i;
        rlast     = bus.mem_rlast_i;
        mrdy      = bus.inct_rready_i;
        burst_end = bus.mem_rvalid_i && bus.inct_rready_i && bus.mem_rlast_i;
      end
      HIT: begin
        rvalid = !hdata_empty;
        rdata  = words[word_idx];
        rlast  = rvalid && (cnt == CNT_LAST);
        if (rvalid && bus.inct_rready_i) begin
          if (rlast) begin
            cnt_nxt   = '0;
            hdata_pop = 1'b1;
            burst_end = 1'b1;
          end else begin
            cnt_nxt = cnt + OFS_W'(1);
          end
        end
      end
      default: ;
    endcase
    // back-to-back bursts: next flag is taken on the last beat, no bubble
    if ((state == IDLE) || burst_end) begin
      if (!flag_empty) begin
        flag_pop  = 1'b1;
        state_nxt = flag_head ? HIT : MISS;
      end else if (burst_end) begin
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign bus.inct_rvalid_o = rvalid;
  assign bus.inct_rdata_o  = rdata;
  assign bus.inct_rlast_o  = rlast;
  assign bus.mem_rready_o  = mrdy;

`ifdef CC_RMU_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (burst_end) begin
      if (state == HIT && hit_cnt != 32'hFFFF_FFFF)  hit_cnt  <= hit_cnt + 32'd1;
      if (state == MISS && miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign bus.hit_cnt_o  = hit_cnt;
  assign bus.miss_cnt_o = miss_cnt;
`else
  assign bus.hit_cnt_o  = '0;
  assign bus.miss_cnt_o = '0;
`endif
endmodule

// File: tb/tb_cc_reorder_merge_unit.sv
// Bench for cc_reorder_merge_unit: directed scenarios plus a randomized run against a beat-stream model.
`timescale 1ns/1ps
module tb_cc_reorder_merge_unit;
  localparam int DW     = 64;
  localparam int BL     = 8;
  localparam int OFS_W  = 3;
  localparam int LINE_W = DW * BL;

  typedef logic [DW:0] beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cc_reorder_merge_unit_if bus ();
  cc_reorder_merge_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int    n_asserts = 0;
  int    n_fails = 0;
  int    cyc = 0;
  int    rdy_mode = 0;
  int    exp_hits = 0;
  int    exp_misses = 0;
  bit    mirror_chk = 1'b0;
  bit    no_mrdy_chk = 1'b0;
  beat_t exp_q[$];
  beat_t obs_q[$];
  beat_t mem_q[$];
  int    obs_cyc[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: output stream is the concatenation of transactions in flag order.
  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic add_hit(input logic [OFS_W-1:0] s, input logic [LINE_W-1:0] line);
    for (int k = 0; k < BL; k++) begin
      int w;
      w = (int'(s) + k) % BL;
      exp_q.push_back({k == BL - 1, line[w*DW +: DW]});
    end
    exp_hits++;
  endtask

  task automatic add_miss(input logic [DW-1:0] base);
    for (int k = 0; k < BL; k++) begin
      beat_t b;
      b = {k == BL - 1, base + DW'(k)};
      mem_q.push_back(b);
      exp_q.push_back(b);
    end
    exp_misses++;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_flag(input logic f);
    bus.hit_flag_fifo_wren_i  = 1'b1;
    bus.hit_flag_fifo_wdata_i = f;
    step(1);
    bus.hit_flag_fifo_wren_i  = 1'b0;
  endtask

  task automatic push_hdata(input logic [OFS_W-1:0] s, input logic [LINE_W-1:0] line);
    bus.hit_data_fifo_wren_i  = 1'b1;
    bus.hit_data_fifo_wdata_i = {s, line};
    step(1);
    bus.hit_data_fifo_wren_i  = 1'b0;
  endtask

  task automatic wait_flag_room();
    int g = 0;
    while (bus.hit_flag_fifo_afull_o && g < 1000) begin step(1); g++; end
    check("flag_room_timeout", 128'(g < 1000), 128'(1));
  endtask

  task automatic wait_hdata_room();
    int g = 0;
    while (bus.hit_data_fifo_afull_o && g < 1000) begin step(1); g++; end
    check("hdata_room_timeout", 128'(g < 1000), 128'(1));
  endtask

  task automatic check_counters();
`ifdef CC_RMU_PERF_CNT_EN
    check("hit_cnt", 128'(bus.hit_cnt_o), 128'(exp_hits));
    check("miss_cnt", 128'(bus.miss_cnt_o), 128'(exp_misses));
`else
    check("hit_cnt", 128'(bus.hit_cnt_o), 128'(0));
    check("miss_cnt", 128'(bus.miss_cnt_o), 128'(0));
`endif
  endtask

  task automatic drain(input string tag, input int budget);
    int g = 0;
    while (obs_q.size() < exp_q.size() && g < budget) begin step(1); g++; end
    step(4);
    check({tag, "_count"}, 128'(obs_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), 128'(obs_q[i]), 128'(exp_q[i]));
    check_counters();
  endtask

  task automatic clear_sb();
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rvalid"}, 128'(bus.inct_rvalid_o), 128'(0));
    check({tag, "_rdata"}, 128'(bus.inct_rdata_o), 128'(0));
    check({tag, "_rlast"}, 128'(bus.inct_rlast_o), 128'(0));
    check({tag, "_mrdy"}, 128'(bus.mem_rready_o), 128'(0));
    check({tag, "_fafull"}, 128'(bus.hit_flag_fifo_afull_o), 128'(0));
    check({tag, "_dafull"}, 128'(bus.hit_data_fifo_afull_o), 128'(0));
    check({tag, "_hcnt"}, 128'(bus.hit_cnt_o), 128'(0));
    check({tag, "_mcnt"}, 128'(bus.miss_cnt_o), 128'(0));
  endtask

  // MEM R source: presents queued beats, holds each until handshake.
  initial begin
    bit take;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    bus.mem_rlast_i  = 1'b0;
    forever begin
      @(negedge clk);
      take = bus.mem_rvalid_i && bus.mem_rready_o;
      @(posedge clk);
      #1;
      if (take && mem_q.size() > 0) void'(mem_q.pop_front());
      if (mem_q.size() > 0) begin
        bus.mem_rvalid_i = 1'b1;
        {bus.mem_rlast_i, bus.mem_rdata_i} = mem_q[0];
      end else begin
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rlast_i  = 1'b0;
      end
    end
  end

  initial begin
    bus.inct_rready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       bus.inct_rready_i = ~bus.inct_rready_i;
        2:       bus.inct_rready_i = 1'($urandom_range(0, 1));
        default: bus.inct_rready_i = 1'b1;
      endcase
    end
  end

  // INCT monitor: the handshake sampled here completes on the next rising edge.
  always @(negedge clk) begin
    cyc++;
    if (mirror_chk) check("miss_rready_mirror", 128'(bus.mem_rready_o), 128'(bus.inct_rready_i));
    if (no_mrdy_chk) check("hit_mem_rready0", 128'(bus.mem_rready_o), 128'(0));
    if (rst_n && bus.inct_rvalid_o && bus.inct_rready_i) begin
      obs_q.push_back({bus.inct_rlast_o, bus.inct_rdata_o});
      obs_cyc.push_back(cyc);
      if (bus.inct_rlast_o) begin
        mirror_chk  = 1'b0;
        no_mrdy_chk = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LINE_W-1:0] line;
    logic [OFS_W-1:0]  s;
    logic              f;
    int                g;
    logic              seq [4];

    bus.hit_flag_fifo_wren_i  = 1'b0;
    bus.hit_flag_fifo_wdata_i = 1'b0;
    bus.hit_data_fifo_wren_i  = 1'b0;
    bus.hit_data_fifo_wdata_i = '0;

    // reset state
    #2;
    check_outputs_zero("in_reset");
    step(3);
    rst_n = 1'b1;
    step(2);
    check_outputs_zero("after_reset");

    // flags 0,1,0 with S=0 line: 24 beats back to back
    for (int k = 0; k < BL; k++) line[k*DW +: DW] = DW'(64'h1000 + k);
    add_miss(64'hA0);
    add_hit(3'd0, line);
    add_miss(64'hB0);
    push_hdata(3'd0, line);
    push_flag(1'b0);
    push_flag(1'b1);
    push_flag(1'b0);
    drain("mhm", 200);
    if (obs_cyc.size() == 24) check("mhm_no_bubble", 128'(obs_cyc[23] - obs_cyc[0]), 128'(23));
    clear_sb();

    // critical word first, S=5
    line = rand_line();
    add_hit(3'd5, line);
    push_hdata(3'd5, line);
    push_flag(1'b1);
    drain("wrap5", 100);
    clear_sb();

    // data lags flag by 3 cycles; MEM beats waiting must not be taken during HIT
    line = rand_line();
    s = 3'($urandom_range(0, 7));
    add_hit(s, line);
    add_miss({$urandom, $urandom});
    push_flag(1'b1);
    repeat (3) begin
      @(negedge clk);
      check("lag_rvalid0", 128'(bus.inct_rvalid_o), 128'(0));
      check("lag_mrdy0", 128'(bus.mem_rready_o), 128'(0));
      @(posedge clk);
      #1;
    end
    no_mrdy_chk = 1'b1;
    push_hdata(s, line);
    push_flag(1'b0);
    drain("lag", 200);
    clear_sb();

    // toggling ready during MISS
    rdy_mode = 1;
    add_miss({$urandom, $urandom});
    push_flag(1'b0);
    step(1);
    mirror_chk = 1'b1;
    drain("toggle", 200);
    clear_sb();
    rdy_mode = 0;
    step(2);

    // reset mid-HIT
    line = rand_line();
    push_hdata(3'd3, line);
    push_flag(1'b1);
    g = 0;
    while (obs_q.size() < 3 && g < 100) begin step(1); g++; end
    check("midhit_start_timeout", 128'(g < 100), 128'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    clear_sb();
    mem_q.delete();
    exp_hits   = 0;
    exp_misses = 0;
    step(2);
    rst_n = 1'b1;
    step(6);
    check("post_reset_no_beats", 128'(obs_q.size()), 128'(0));

    // flag FIFO almost full and overflow drop (3 hits + 2 misses)
    line = rand_line();
    add_hit(3'd1, line);
    push_flag(1'b1);
    step(2);
    check("flag_afull_0", 128'(bus.hit_flag_fifo_afull_o), 128'(0));
    seq[0] = 1'b0; seq[1] = 1'b1; seq[2] = 1'b0; seq[3] = 1'b1;
    add_miss({$urandom, $urandom});
    add_hit(3'd6, rand_line());
    add_miss({$urandom, $urandom});
    add_hit(3'd2, rand_line());
    for (int i = 0; i < 4; i++) begin
      push_flag(seq[i]);
      check($sformatf("flag_afull_%0d", i + 1), 128'(bus.hit_flag_fifo_afull_o), 128'(i >= 1));
    end
    for (int k = 0; k < BL; k++) mem_q.push_back({k == BL - 1, DW'(64'h5E17_0000 + k)});
    push_flag(1'b0);
    check("flag_afull_full", 128'(bus.hit_flag_fifo_afull_o), 128'(1));
    push_hdata(3'd1, line);
    check("hdata_afull_1", 128'(bus.hit_data_fifo_afull_o), 128'(1));
    for (int h = 1; h < 3; h++) begin
      logic [LINE_W-1:0] hl;
      wait_hdata_room();
      for (int k = 0; k < BL; k++) hl[k*DW +: DW] = exp_q[h*2*BL + k - h * 0][DW-1:0];
      // recover the queued line from the model in flat (unrotated) order
      s = (h == 1) ? 3'd6 : 3'd2;
      for (int k = 0; k < BL; k++) hl[((int'(s) + k) % BL)*DW +: DW] = exp_q[(2*h)*BL + k][DW-1:0];
      push_hdata(s, hl);
    end
    drain("afull", 600);
    step(10);
    check("dropped_flag_no_extra", 128'(obs_q.size()), 128'(exp_q.size()));
    clear_sb();
    mem_q.delete();
    step(3);

    // randomized mix with random ready
    rdy_mode = 2;
    for (int t = 0; t < 24; t++) begin
      f = 1'($urandom_range(0, 1));
      if (f) begin
        line = rand_line();
        s = 3'($urandom_range(0, 7));
        add_hit(s, line);
        wait_flag_room();
        push_flag(1'b1);
        wait_hdata_room();
        push_hdata(s, line);
      end else begin
        add_miss({$urandom, $urandom});
        wait_flag_room();
        push_flag(1'b0);
      end
    end
    drain("random", 4000);
    clear_sb();
    rdy_mode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end
endmodule
